// File: rtl/gold_descrambler.sv
// Gold-sequence descrambler: pairs each incoming soft LLR with one buffered
// sequence bit and sign-flips (with saturation) the LLR when that bit is 1.
// A small bit FIFO decouples the sequence generator from LLR arrival.
module gold_descrambler #(
    parameter int LLR_W      = 8,
    parameter int NBITS      = 864,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             c_bit,
    input  logic             c_valid,
    input  logic [LLR_W-1:0] llr_in,
    input  logic             llr_valid,
    output logic             llr_ready,
    output logic [LLR_W-1:0] llr_out,
    output logic             out_valid,
    output logic             out_last,
    output logic             done,
    output logic             c_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(NBITS + 1);

    localparam logic [LLR_W-1:0] LLR_MIN = {1'b1, {(LLR_W-1){1'b0}}};
    localparam logic [LLR_W-1:0] LLR_MAX = ~LLR_MIN;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [FIFO_DEPTH-1:0]   mem;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             occ;

    logic             empty;
    logic             full;
    logic             xfer;
    logic             push;
    logic             push_ok;
    logic             seq_bit;
    logic             last_xfer;
    logic [LLR_W-1:0] llr_neg;

    assign empty     = (occ == '0);
    assign full      = (occ == (AW+1)'(FIFO_DEPTH));
    assign llr_ready = (state == RUN) && !empty;
    assign xfer      = llr_valid && llr_ready;
    // start flushes the FIFO, so a same-cycle sequence bit is discarded
    assign push      = (state == RUN) && c_valid && !start;
    // a pop in the same cycle frees the slot, so a push at full is still legal
    assign push_ok   = push && (!full || xfer);
    assign seq_bit   = mem[rd_ptr];
    assign last_xfer = xfer && (cnt == CW'(NBITS - 1));
    // the most negative code has no positive twin; clamp it to the maximum
    assign llr_neg   = (llr_in == LLR_MIN) ? LLR_MAX : (LLR_W'(0) - llr_in);

    // Sequence-bit FIFO with occupancy count and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            c_overflow <= 1'b0;
        end else if (start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            c_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= c_bit;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (xfer)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !xfer)
                occ <= occ + 1'b1;
            else if (!push_ok && xfer)
                occ <= occ - 1'b1;
            if (push && !push_ok)
                c_overflow <= 1'b1;
        end
    end

    // Pass control: counts transfers and emits a one-cycle done in FIN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (start) begin
            state <= RUN;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: done <= 1'b0;
                RUN: begin
                    if (xfer)
                        cnt <= cnt + 1'b1;
                    if (last_xfer) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Output register: one-cycle latency, llr_out holds between transfers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llr_out   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= xfer;
            // a restart in the same cycle abandons the pass, so no last marker
            out_last  <= last_xfer && !start;
            if (xfer)
                llr_out <= seq_bit ? llr_neg : llr_in;
        end
    end

endmodule
